// File: rtl/xosera_bus_initiator.sv
// xosera_bus_initiator
// Host-side initiator for the Xosera 8-bit register bus. Each 16-bit request
// becomes two byte cycles (MSB with bytesel=0, then LSB with bytesel=1), each
// cycle being SETUP -> STROBE (cs_n low) -> HOLD. All bus outputs are registered.
// Optional feature macro: XOSERA_BUS_INTR_SYNC_EN adds a 2-flop interrupt
// synchronizer and a rising-edge pulse; without it the interrupt is a wire.
module xosera_bus_initiator #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_wr_i,
    input  logic [3:0]  req_reg_i,
    input  logic [15:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [15:0] rsp_rdata_o,
    output logic        bus_cs_n_o,
    output logic        bus_rd_nwr_o,
    output logic [3:0]  bus_reg_num_o,
    output logic        bus_bytesel_o,
    output logic [7:0]  bus_data_o,
    input  logic [7:0]  bus_data_i,
    input  logic        bus_intr_i,
    output logic        intr_o,
    output logic        intr_pulse_o
);
    localparam int unsigned MAX_AB  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int unsigned MAX_CYC = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

    // Counter reload values: the counter counts down to zero, so a phase of
    // N cycles loads N-1 on entry.
    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             byte_q, byte_d;        // 0 = MSB cycle, 1 = LSB cycle
    logic             wr_q, wr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic [7:0]       shadow_msb_q, shadow_msb_d;
    logic [7:0]       shadow_lsb_q, shadow_lsb_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [15:0]      rsp_rdata_q, rsp_rdata_d;
    logic             cs_n_q, cs_n_d;
    logic             rd_nwr_q, rd_nwr_d;
    logic [3:0]       reg_num_q, reg_num_d;
    logic             bytesel_q, bytesel_d;
    logic [7:0]       data_q, data_d;

    // Next-state, phase counter and registered bus outputs for the access sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        byte_d       = byte_q;
        wr_d         = wr_q;
        wdata_d      = wdata_q;
        shadow_msb_d = shadow_msb_q;
        shadow_lsb_d = shadow_lsb_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        cs_n_d       = cs_n_q;
        rd_nwr_d     = rd_nwr_q;
        reg_num_d    = reg_num_q;
        bytesel_d    = bytesel_q;
        data_d       = data_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    wr_d      = req_wr_i;
                    wdata_d   = req_wdata_i;
                    byte_d    = 1'b0;
                    state_d   = ST_SETUP;
                    cnt_d     = SETUP_LOAD;
                    cs_n_d    = 1'b1;
                    rd_nwr_d  = ~req_wr_i;
                    reg_num_d = req_reg_i;
                    bytesel_d = 1'b0;
                    data_d    = req_wr_i ? req_wdata_i[15:8] : 8'h00;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_STROBE;
                    cnt_d   = STROBE_LOAD;
                    cs_n_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    // Read data is sampled at the end of the last strobe cycle.
                    if (!wr_q) begin
                        if (byte_q) shadow_lsb_d = bus_data_i;
                        else        shadow_msb_d = bus_data_i;
                    end
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                    cs_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    if (!byte_q) begin
                        byte_d    = 1'b1;
                        state_d   = ST_SETUP;
                        cnt_d     = SETUP_LOAD;
                        bytesel_d = 1'b1;
                        data_d    = wr_q ? wdata_q[7:0] : 8'h00;
                    end else begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                // Response is registered here, so it appears as we re-enter IDLE.
                rsp_valid_d = 1'b1;
                if (!wr_q) rsp_rdata_d = {shadow_msb_q, shadow_lsb_q};
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cs_n_d  = 1'b1;
            end
        endcase
    end

    // State and output registers; reset drops chip select and abandons any access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            byte_q       <= 1'b0;
            wr_q         <= 1'b0;
            wdata_q      <= 16'h0000;
            shadow_msb_q <= 8'h00;
            shadow_lsb_q <= 8'h00;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 16'h0000;
            cs_n_q       <= 1'b1;
            rd_nwr_q     <= 1'b1;
            reg_num_q    <= 4'h0;
            bytesel_q    <= 1'b0;
            data_q       <= 8'h00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            byte_q       <= byte_d;
            wr_q         <= wr_d;
            wdata_q      <= wdata_d;
            shadow_msb_q <= shadow_msb_d;
            shadow_lsb_q <= shadow_lsb_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            cs_n_q       <= cs_n_d;
            rd_nwr_q     <= rd_nwr_d;
            reg_num_q    <= reg_num_d;
            bytesel_q    <= bytesel_d;
            data_q       <= data_d;
        end
    end

    assign req_ready_o   = (state_q == ST_IDLE);
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign bus_cs_n_o    = cs_n_q;
    assign bus_rd_nwr_o  = rd_nwr_q;
    assign bus_reg_num_o = reg_num_q;
    assign bus_bytesel_o = bytesel_q;
    assign bus_data_o    = data_q;

`ifdef XOSERA_BUS_INTR_SYNC_EN
    logic intr_meta_q, intr_meta_d;
    logic intr_sync_q, intr_sync_d;
    logic intr_pulse_q, intr_pulse_d;

    // Two-stage synchronizer; the pulse fires when the second stage is about to rise.
    always_comb begin
        intr_meta_d  = bus_intr_i;
        intr_sync_d  = intr_meta_q;
        intr_pulse_d = intr_meta_q & ~intr_sync_q;
    end

    // Synchronizer and pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            intr_meta_q  <= 1'b0;
            intr_sync_q  <= 1'b0;
            intr_pulse_q <= 1'b0;
        end else begin
            intr_meta_q  <= intr_meta_d;
            intr_sync_q  <= intr_sync_d;
            intr_pulse_q <= intr_pulse_d;
        end
    end

    assign intr_o       = intr_sync_q;
    assign intr_pulse_o = intr_pulse_q;
`else
    assign intr_o       = bus_intr_i;
    assign intr_pulse_o = 1'b0;
`endif

endmodule

// File: tb/tb_xosera_bus_initiator.sv
// Directed bench for xosera_bus_initiator: a default-timing instance talking to
// a small Xosera register-file model, plus a slow-timing instance (S=2,T=3,H=2).
module tb_xosera_bus_initiator;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_wr;
    logic [3:0]  req_reg;
    logic [15:0] req_wdata;
    logic        req_ready, rsp_valid;
    logic [15:0] rsp_rdata;
    logic        cs_n, rd_nwr, bytesel;
    logic [3:0]  reg_num;
    logic [7:0]  data_o, data_i;
    logic        intr_in, intr_o, intr_pulse;

    logic        s_valid, s_wr;
    logic [3:0]  s_reg;
    logic [15:0] s_wdata;
    logic        s_ready, s_rsp_valid;
    logic [15:0] s_rdata;
    logic        s_cs_n, s_rd_nwr, s_bytesel;
    logic [3:0]  s_reg_num;
    logic [7:0]  s_data_o;
    logic        s_intr, s_intr_pulse;

    int total = 0;
    int bad   = 0;

    xosera_bus_initiator dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wr_i(req_wr),
        .req_reg_i(req_reg), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
        .bus_cs_n_o(cs_n), .bus_rd_nwr_o(rd_nwr), .bus_reg_num_o(reg_num),
        .bus_bytesel_o(bytesel), .bus_data_o(data_o), .bus_data_i(data_i),
        .bus_intr_i(intr_in), .intr_o(intr_o), .intr_pulse_o(intr_pulse)
    );

    xosera_bus_initiator #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2)) dut_slow (
        .clk(clk), .reset(reset),
        .req_valid_i(s_valid), .req_ready_o(s_ready), .req_wr_i(s_wr),
        .req_reg_i(s_reg), .req_wdata_i(s_wdata),
        .rsp_valid_o(s_rsp_valid), .rsp_rdata_o(s_rdata),
        .bus_cs_n_o(s_cs_n), .bus_rd_nwr_o(s_rd_nwr), .bus_reg_num_o(s_reg_num),
        .bus_bytesel_o(s_bytesel), .bus_data_o(s_data_o), .bus_data_i(8'h00),
        .bus_intr_i(1'b0), .intr_o(s_intr), .intr_pulse_o(s_intr_pulse)
    );

    // Register-file model of Xosera, plus a watcher for cs_n spanning a byte change.
    logic [15:0] model [16];
    int          pl_seq = 0, pl_seen = 0;
    logic [3:0]  pl_reg;
    logic [15:0] pl_val;
    int          bnd_viol = 0;
    logic        prev_cs = 1'b1, prev_bs = 1'b0;

    initial for (int i = 0; i < 16; i++) model[i] = 16'h0000;

    always @(negedge clk) begin
        if (pl_seq != pl_seen) begin
            model[pl_reg] = pl_val;
            pl_seen = pl_seq;
        end
        if (!reset && !cs_n && !rd_nwr) begin
            if (bytesel) model[reg_num][7:0]  = data_o;
            else         model[reg_num][15:8] = data_o;
        end
        if (!cs_n && !prev_cs && (bytesel != prev_bs)) bnd_viol++;
        prev_cs = cs_n;
        prev_bs = bytesel;
    end

    logic [15:0] cur_reg;
    always_comb begin
        cur_reg = model[reg_num];
        data_i  = bytesel ? cur_reg[7:0] : cur_reg[15:8];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [3:0] r, input logic [15:0] v);
        pl_reg = r;
        pl_val = v;
        pl_seq++;
        tick();
    endtask

    // Full access on the default instance; lat = edges from accept to rsp_valid, -1 on timeout.
    task automatic do_access(input logic wr, input logic [3:0] r, input logic [15:0] wd,
                             output logic [15:0] rd, output int lat);
        int n;
        n = 0;
        req_valid = 1'b1; req_wr = wr; req_reg = r; req_wdata = wd;
        while (!req_ready && n < 50) begin tick(); n++; end
        tick();
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin tick(); lat++; end
        if (!rsp_valid) lat = -1;
        rd = rsp_rdata;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 1'b0; req_wr = 1'b0; req_reg = 4'h0; req_wdata = 16'h0000;
        s_valid = 1'b0; s_wr = 1'b0; s_reg = 4'h0; s_wdata = 16'h0000;
        intr_in = 1'b0;
        repeat (3) tick();
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if (rsp_rdata !== 16'h0000) begin bad++; $display("FAIL reset_rdata got=%h exp=0000", rsp_rdata); end
        total++; if (cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n got=%b exp=1", cs_n); end
        total++; if (rd_nwr !== 1'b1) begin bad++; $display("FAIL reset_rd_nwr got=%b exp=1", rd_nwr); end
        total++; if (reg_num !== 4'h0) begin bad++; $display("FAIL reset_reg_num got=%h exp=0", reg_num); end
        total++; if (bytesel !== 1'b0) begin bad++; $display("FAIL reset_bytesel got=%b exp=0", bytesel); end
        total++; if (data_o !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data_o); end
        total++; if (intr_pulse !== 1'b0) begin bad++; $display("FAIL reset_intr_pulse got=%b exp=0", intr_pulse); end
        reset = 1'b0;
        tick();
        $display("reset: checked reset values");
    endtask

    // Write reg3 = A55A, checked edge by edge (k = edges after accept).
    task automatic test_write();
        logic [9:0] exp_cs, exp_rsp;
        exp_cs  = 10'b1110011001;
        exp_rsp = 10'b1000000000;
        req_valid = 1'b1; req_wr = 1'b1; req_reg = 4'h3; req_wdata = 16'hA55A;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) tick();
            total++; if (cs_n !== exp_cs[k]) begin bad++; $display("FAIL wr_cs_n k=%0d got=%b exp=%b", k, cs_n, exp_cs[k]); end
            total++; if (rsp_valid !== exp_rsp[k]) begin bad++; $display("FAIL wr_rsp_valid k=%0d got=%b exp=%b", k, rsp_valid, exp_rsp[k]); end
            if (k == 0) begin
                total++; if ({rd_nwr, reg_num, bytesel, data_o} !== {1'b0, 4'h3, 1'b0, 8'hA5}) begin
                    bad++; $display("FAIL wr_byte0 got rd_nwr=%b reg=%h bs=%b data=%h exp 0/3/0/a5", rd_nwr, reg_num, bytesel, data_o); end
                total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL wr_busy got=%b exp=0", req_ready); end
            end
            if (k == 4) begin
                total++; if ({bytesel, data_o} !== {1'b1, 8'h5A}) begin
                    bad++; $display("FAIL wr_byte1 got bs=%b data=%h exp 1/5a", bytesel, data_o); end
            end
            if (k == 9) begin
                total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL wr_ready_back got=%b exp=1", req_ready); end
            end
        end
        total++; if (model[3] !== 16'hA55A) begin bad++; $display("FAIL wr_model reg3 got=%h exp=a55a", model[3]); end
        $display("write: reg3 <= a55a model=%h", model[3]);
    endtask

    // Read reg3 with the model holding BEEF.
    task automatic test_read();
        preload(4'h3, 16'hBEEF);
        req_valid = 1'b1; req_wr = 1'b0; req_reg = 4'h3; req_wdata = 16'h1111;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) tick();
            if (k == 0 || k == 4) begin
                total++; if ({rd_nwr, data_o} !== {1'b1, 8'h00}) begin
                    bad++; $display("FAIL rd_setup k=%0d got rd_nwr=%b data=%h exp 1/00", k, rd_nwr, data_o); end
            end
            if (k == 8) begin
                total++; if ({rsp_valid, rsp_rdata} !== {1'b0, 16'h0000}) begin
                    bad++; $display("FAIL rd_early k=8 got v=%b d=%h exp 0/0000", rsp_valid, rsp_rdata); end
            end
            if (k == 9) begin
                total++; if ({rsp_valid, rsp_rdata} !== {1'b1, 16'hBEEF}) begin
                    bad++; $display("FAIL rd_rsp k=9 got v=%b d=%h exp 1/beef", rsp_valid, rsp_rdata); end
            end
        end
        tick();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_pulse_width got=%b exp=0", rsp_valid); end
        $display("read: reg3 -> %h", rsp_rdata);
    endtask

    // Two writes with req_valid held; second accept on the edge after the first rsp_valid.
    task automatic test_back_to_back();
        int viol0;
        viol0 = bnd_viol;
        req_valid = 1'b1; req_wr = 1'b1; req_reg = 4'h5; req_wdata = 16'h1234;
        tick();
        req_reg = 4'h6; req_wdata = 16'h5678;
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) tick();
            total++; if (rsp_valid !== (k == 9 || k == 19)) begin
                bad++; $display("FAIL b2b_rsp k=%0d got=%b exp=%b", k, rsp_valid, (k == 9 || k == 19)); end
            total++; if (req_ready !== (k == 9 || k >= 19)) begin
                bad++; $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, req_ready, (k == 9 || k >= 19)); end
            if (k == 10) req_valid = 1'b0;
        end
        total++; if (model[5] !== 16'h1234) begin bad++; $display("FAIL b2b_reg5 got=%h exp=1234", model[5]); end
        total++; if (model[6] !== 16'h5678) begin bad++; $display("FAIL b2b_reg6 got=%h exp=5678", model[6]); end
        total++; if (bnd_viol != viol0) begin bad++; $display("FAIL b2b_cs_boundary got=%0d exp=%0d", bnd_viol, viol0); end
        total++; if (rsp_rdata !== 16'hBEEF) begin bad++; $display("FAIL b2b_rdata_hold got=%h exp=beef", rsp_rdata); end
        $display("back_to_back: reg5=%h reg6=%h", model[5], model[6]);
    endtask

    // Reset during the byte-1 strobe, then a clean read.
    task automatic test_reset_mid();
        logic [15:0] rd;
        int lat;
        preload(4'h7, 16'h1357);
        req_valid = 1'b1; req_wr = 1'b0; req_reg = 4'h7; req_wdata = 16'h0000;
        tick();
        req_valid = 1'b0;
        repeat (5) tick();
        total++; if ({cs_n, bytesel} !== 2'b01) begin bad++; $display("FAIL rm_in_strobe got cs_n=%b bs=%b exp 0/1", cs_n, bytesel); end
        reset = 1'b1;
        tick();
        total++; if ({cs_n, rsp_valid} !== 2'b10) begin bad++; $display("FAIL rm_abort got cs_n=%b v=%b exp 1/0", cs_n, rsp_valid); end
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rm_no_rsp k=%0d got=%b exp=0", k, rsp_valid); end
        end
        total++; if ({req_ready, rsp_rdata} !== {1'b1, 16'h0000}) begin
            bad++; $display("FAIL rm_after got ready=%b d=%h exp 1/0000", req_ready, rsp_rdata); end
        do_access(1'b0, 4'h7, 16'h0000, rd, lat);
        total++; if (rd !== 16'h1357) begin bad++; $display("FAIL rm_read got=%h exp=1357", rd); end
        total++; if (lat != 9) begin bad++; $display("FAIL rm_latency got=%0d exp=9", lat); end
        $display("reset_mid: read reg7 -> %h lat=%0d", rd, lat);
    endtask

    // Slow instance: cs_n pulses of 3 cycles, response 15 edges after accept.
    task automatic test_slow_timing();
        int run, pulses, lat, nrsp;
        run = 0; pulses = 0; lat = -1; nrsp = 0;
        s_valid = 1'b1; s_wr = 1'b1; s_reg = 4'h2; s_wdata = 16'hC33C;
        tick();
        s_valid = 1'b0;
        total++; if (s_cs_n !== 1'b1) begin bad++; $display("FAIL slow_k0_cs_n got=%b exp=1", s_cs_n); end
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (!s_cs_n) run++;
            else if (run > 0) begin
                pulses++;
                total++; if (run != 3) begin bad++; $display("FAIL slow_strobe_len pulse=%0d got=%0d exp=3", pulses, run); end
                run = 0;
            end
            if (s_rsp_valid) begin
                nrsp++;
                if (lat < 0) lat = k;
            end
        end
        total++; if (pulses != 2) begin bad++; $display("FAIL slow_pulses got=%0d exp=2", pulses); end
        total++; if (lat != 15) begin bad++; $display("FAIL slow_latency got=%0d exp=15", lat); end
        total++; if (nrsp != 1) begin bad++; $display("FAIL slow_rsp_count got=%0d exp=1", nrsp); end
        $display("slow_timing: pulses=%0d lat=%0d", pulses, lat);
    endtask

    task automatic test_intr();
        int npulse;
        npulse = 0;
        intr_in = 1'b0;
        repeat (3) tick();
        total++; if (intr_o !== 1'b0) begin bad++; $display("FAIL intr_idle got=%b exp=0", intr_o); end
        intr_in = 1'b1;
`ifdef XOSERA_BUS_INTR_SYNC_EN
        for (int k = 1; k <= 5; k++) begin
            tick();
            total++; if (intr_o !== (k >= 2)) begin bad++; $display("FAIL intr_sync k=%0d got=%b exp=%b", k, intr_o, (k >= 2)); end
            total++; if (intr_pulse !== (k == 2)) begin bad++; $display("FAIL intr_pulse k=%0d got=%b exp=%b", k, intr_pulse, (k == 2)); end
            if (intr_pulse) npulse++;
        end
`else
        #1;
        total++; if (intr_o !== 1'b1) begin bad++; $display("FAIL intr_comb got=%b exp=1", intr_o); end
        for (int k = 1; k <= 5; k++) begin
            tick();
            total++; if (intr_pulse !== 1'b0) begin bad++; $display("FAIL intr_pulse k=%0d got=%b exp=0", k, intr_pulse); end
            if (intr_pulse) npulse++;
        end
`endif
        intr_in = 1'b0;
        tick();
        $display("intr: pulses=%0d", npulse);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_slow_timing();
        test_intr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound in case a wait loop misbehaves.
    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
